delay_pipe: RTL and testbench

Parametrised, valid-tagged delay line for the SDRAM controller datapath. It delays a WIDTH-bit word plus its valid flag by a depth selected at run time, from 0 to MAX_DEPTH cycles. It supports pipeline hold (stall), synchronous flush, and reports whether any valid word is in flight. It aligns read data, strobes and command tags against CAS latency, which is programmed from the mode register rather than fixed at build time.

---
 rtl/delay_pipe_pkg.sv | 27 ++
 rtl/delay_pipe_stage.sv | 47 ++++
 rtl/delay_pipe.sv | 81 ++++++++
 tb/tb_delay_pipe.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/delay_pipe_pkg.sv
// delay_pipe_pkg: shared sizing/clamp helpers and the stage record for delay_pipe.
// Contents: dp_depth_w (width of depth_sel/occ), dp_clamp (tap select clamp),
//           dp_stage_t (default-width {vld, data} stage record).
package delay_pipe_pkg;

  localparam int unsigned DP_DEF_WIDTH     = 16;
  localparam int unsigned DP_DEF_MAX_DEPTH = 8;

  // One pipeline stage at the default word width. Instances at other widths
  // keep the same {vld, data} shape, with vld in the top bit.
  typedef struct packed {
    logic                    vld;
    logic [DP_DEF_WIDTH-1:0] data;
  } dp_stage_t;

  // Bits needed to encode 0..max_depth.
  function automatic int unsigned dp_depth_w(input int unsigned max_depth);
    return $unsigned($clog2(max_depth + 1));
  endfunction

  // Run-time depth clamped to the physical stage count.
  function automatic int unsigned dp_clamp(input int unsigned sel,
                                           input int unsigned max_depth);
    return (sel > max_depth) ? max_depth : sel;
  endfunction

endpackage

// File: rtl/delay_pipe_stage.sv
// delay_pipe_stage: one {vld, data} register of the delay line.
// Ports: clk, rst (sync, active-low), clear, en, vld_i/data_i from the previous
//        stage, vld_o/data_o to the next stage and the tap mux.
module delay_pipe_stage #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic             vld_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] data_o
);

  logic             vld_q,  vld_d;
  logic [WIDTH-1:0] data_q, data_d;

  // clear beats en; an invalid word is stored as zero so a stage with
  // vld=0 never carries stale data.
  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (clear) begin
      vld_d  = 1'b0;
      data_d = '0;
    end else if (en) begin
      vld_d  = vld_i;
      data_d = vld_i ? data_i : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign vld_o  = vld_q;
  assign data_o = data_q;

endmodule

// File: rtl/delay_pipe.sv
// delay_pipe: valid-tagged delay line with run-time depth 0..MAX_DEPTH, stall and flush.
// Ports: clk, rst (sync, active-low), d/d_vld in, en (advance), clear (flush),
//        depth_sel (tap), q/q_vld out, busy, occ (only with DELAY_PIPE_OCC_EN defined).
module delay_pipe
  import delay_pipe_pkg::*;
#(
  parameter int unsigned WIDTH     = DP_DEF_WIDTH,
  parameter int unsigned MAX_DEPTH = DP_DEF_MAX_DEPTH,
  parameter int unsigned DEPTH_W   = dp_depth_w(MAX_DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   d,
  input  logic               d_vld,
  input  logic               en,
  input  logic               clear,
  input  logic [DEPTH_W-1:0] depth_sel,
  output logic [WIDTH-1:0]   q,
  output logic               q_vld,
  output logic               busy
`ifdef DELAY_PIPE_OCC_EN
  ,
  output logic [DEPTH_W-1:0] occ
`endif
);

  // Index 0 is the live input; 1..MAX_DEPTH are the registered stages.
  logic             vld_s  [MAX_DEPTH+1];
  logic [WIDTH-1:0] data_s [MAX_DEPTH+1];
  logic [DEPTH_W-1:0] eff_depth;

  assign vld_s[0]  = d_vld;
  assign data_s[0] = d;

  for (genvar i = 1; i <= MAX_DEPTH; i++) begin : g_stage
    delay_pipe_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk    (clk),
      .rst    (rst),
      .clear  (clear),
      .en     (en),
      .vld_i  (vld_s[i-1]),
      .data_i (data_s[i-1]),
      .vld_o  (vld_s[i]),
      .data_o (data_s[i])
    );
  end

  assign eff_depth = DEPTH_W'(dp_clamp(32'(depth_sel), MAX_DEPTH));

  // With eff_depth=0 no stage matches, leaving the combinational bypass.
  // Stages beyond the tap are ignored entirely, so shrinking the depth
  // abandons them rather than draining them.
  always_comb begin
    q     = d;
    q_vld = d_vld;
    busy  = 1'b0;
    for (int unsigned i = 1; i <= MAX_DEPTH; i++) begin
      if (DEPTH_W'(i) == eff_depth) begin
        q     = data_s[i];
        q_vld = vld_s[i];
      end
      if (DEPTH_W'(i) <= eff_depth) begin
        busy = busy | vld_s[i];
      end
    end
  end

`ifdef DELAY_PIPE_OCC_EN
  always_comb begin
    occ = '0;
    for (int unsigned i = 1; i <= MAX_DEPTH; i++) begin
      if ((DEPTH_W'(i) <= eff_depth) && vld_s[i]) begin
        occ = occ + DEPTH_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_delay_pipe.sv
module tb_delay_pipe;

  localparam int MAXD = 8;

  logic        clk;
  logic        rst;
  logic [15:0] d;
  logic        d_vld;
  logic        en;
  logic        clear;
  logic [3:0]  depth_sel;
  logic [15:0] q;
  logic        q_vld;
  logic        busy;
`ifdef DELAY_PIPE_OCC_EN
  logic [3:0]  occ;
`endif

  delay_pipe #(
    .WIDTH     (16),
    .MAX_DEPTH (MAXD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .d         (d),
    .d_vld     (d_vld),
    .en        (en),
    .clear     (clear),
    .depth_sel (depth_sel),
    .q         (q),
    .q_vld     (q_vld),
    .busy      (busy)
`ifdef DELAY_PIPE_OCC_EN
    ,
    .occ       (occ)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // ---------------- reference model ----------------
  // hist[k] is the word captured k+1 enabled edges ago (zero if invalid).
  typedef struct packed {
    logic        vld;
    logic [15:0] dat;
  } rec_t;
  rec_t hist[$];

  function automatic int eff_of(input int s);
    return (s > MAXD) ? MAXD : s;
  endfunction

  task automatic model_flush();
    hist.delete();
    for (int k = 0; k < MAXD; k++) hist.push_back('0);
  endtask

  task automatic model_out(output logic [15:0] eq, output logic ev,
                           output logic eb, output int eo);
    int e;
    e  = eff_of(int'(depth_sel));
    eb = 1'b0;
    eo = 0;
    if (e == 0) begin
      eq = d;
      ev = d_vld;
    end else begin
      eq = hist[e-1].dat;
      ev = hist[e-1].vld;
    end
    for (int k = 0; k < e; k++) begin
      if (hist[k].vld) begin
        eb = 1'b1;
        eo++;
      end
    end
  endtask

  task automatic model_edge();
    rec_t r;
    if (!rst || clear) begin
      model_flush();
    end else if (en) begin
      r.vld = d_vld;
      r.dat = d_vld ? d : 16'h0;
      hist.push_front(r);
      void'(hist.pop_back());
    end
  endtask

  // ---------------- drive / check ----------------
  task automatic drive(input logic r, input logic c, input logic e, input logic v,
                       input logic [15:0] dd, input logic [3:0] s);
    @(negedge clk);
    rst = r; clear = c; en = e; d_vld = v; d = dd; depth_sel = s;
    #1;
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge();
  endtask

  task automatic check(input string nm, input logic [15:0] eq, input logic ev,
                       input logic eb, input int eo);
    bit ok;
    n_vec++;
    ok = (q === eq) && (q_vld === ev) && (busy === eb);
`ifdef DELAY_PIPE_OCC_EN
    ok = ok && (occ === 4'(eo));
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got q=%h q_vld=%b busy=%b occ=%0d, want q=%h q_vld=%b busy=%b occ=%0d",
               nm, q, q_vld, busy, occ, eq, ev, eb, eo);
    end
`else
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got q=%h q_vld=%b busy=%b, want q=%h q_vld=%b busy=%b (occ %0d)",
               nm, q, q_vld, busy, eq, ev, eb, eo);
    end
`endif
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        r, c, e, v;
    logic [15:0] dd;
    logic [3:0]  s;
    bit          chk;
    logic [15:0] eq;
    logic        ev, eb;
    int          eo;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic r, input logic c, input logic e, input logic v,
                     input logic [15:0] dd, input logic [3:0] s, input bit chk,
                     input logic [15:0] eq, input logic ev, input logic eb, input int eo);
    vec_t t;
    t.r = r; t.c = c; t.e = e; t.v = v; t.dd = dd; t.s = s;
    t.chk = chk; t.eq = eq; t.ev = ev; t.eb = eb; t.eo = eo;
    tbl.push_back(t);
  endtask

  initial begin
    logic [15:0] eq;
    logic        ev, eb;
    int          eo;
    logic [3:0]  rs;

    rst = 1'b0; clear = 1'b0; en = 1'b0; d_vld = 1'b0; d = '0; depth_sel = '0;
    model_flush();

    //   rst clr en vld data      sel chk  q        qv busy occ
    add(0, 0, 1, 1, 16'hAAAA,  3, 0, 16'h0000, 0, 0, 0);   // reset edge
    add(1, 0, 1, 0, 16'hFFFF,  3, 1, 16'h0000, 0, 0, 0);   // reset state
    add(1, 0, 1, 1, 16'h1234,  3, 1, 16'h0000, 0, 0, 0);   // fixed depth c0
    add(1, 0, 1, 0, 16'hFFFF,  3, 1, 16'h0000, 0, 1, 1);
    add(1, 0, 1, 0, 16'hFFFF,  3, 1, 16'h0000, 0, 1, 1);
    add(1, 0, 1, 0, 16'h0000,  3, 1, 16'h1234, 1, 1, 1);   // c3: word at tap
    add(1, 0, 1, 0, 16'h0000,  3, 1, 16'h0000, 0, 0, 0);   // gated FFFF reads 0
    add(1, 0, 1, 1, 16'hBEEF,  0, 1, 16'hBEEF, 1, 0, 0);   // bypass
    add(1, 1, 1, 1, 16'h5555,  2, 1, 16'h0000, 0, 1, 1);   // clear, BEEF in s1
    add(1, 0, 1, 1, 16'h7777,  2, 1, 16'h0000, 0, 0, 0);   // stall c0
    add(1, 0, 0, 1, 16'h1111,  2, 1, 16'h0000, 0, 1, 1);
    add(1, 0, 0, 1, 16'h2222,  2, 1, 16'h0000, 0, 1, 1);
    add(1, 0, 0, 1, 16'h3333,  2, 1, 16'h0000, 0, 1, 1);
    add(1, 0, 1, 0, 16'h0000,  2, 1, 16'h0000, 0, 1, 1);
    add(1, 0, 1, 0, 16'h0000,  2, 1, 16'h7777, 1, 1, 1);   // c5: word out
    add(1, 0, 1, 0, 16'h0000,  2, 1, 16'h0000, 0, 0, 0);
    add(1, 1, 1, 0, 16'h0000,  2, 1, 16'h0000, 0, 0, 0);   // clear stale
    add(1, 0, 1, 1, 16'hA001,  4, 1, 16'h0000, 0, 0, 0);   // flush c0
    add(1, 0, 1, 1, 16'hA002,  4, 1, 16'h0000, 0, 1, 1);
    add(1, 1, 1, 1, 16'hA003,  4, 1, 16'h0000, 0, 1, 2);   // clear+en
    add(1, 0, 1, 0, 16'h0000,  4, 1, 16'h0000, 0, 0, 0);
    add(1, 0, 1, 0, 16'h0000,  4, 1, 16'h0000, 0, 0, 0);
    add(1, 0, 1, 0, 16'h0000,  4, 1, 16'h0000, 0, 0, 0);
    add(1, 0, 1, 1, 16'hB001, 15, 1, 16'h0000, 0, 0, 0);   // clamp c0
    add(1, 0, 1, 1, 16'hB002, 15, 1, 16'h0000, 0, 1, 1);
    add(1, 0, 1, 1, 16'hB003, 15, 1, 16'h0000, 0, 1, 2);
    add(1, 0, 1, 1, 16'hB004, 15, 1, 16'h0000, 0, 1, 3);
    add(1, 0, 1, 1, 16'hB005, 15, 1, 16'h0000, 0, 1, 4);
    add(1, 0, 1, 0, 16'h0000, 15, 1, 16'h0000, 0, 1, 5);
    add(1, 0, 1, 0, 16'h0000, 15, 1, 16'h0000, 0, 1, 5);
    add(1, 0, 1, 0, 16'h0000, 15, 1, 16'h0000, 0, 1, 5);
    add(1, 0, 1, 0, 16'h0000, 15, 1, 16'hB001, 1, 1, 5);   // c8
    add(1, 0, 1, 0, 16'h0000, 15, 1, 16'hB002, 1, 1, 4);
    add(0, 0, 1, 1, 16'hC0DE, 15, 1, 16'hB003, 1, 1, 3);   // reset, 3 in flight
    add(1, 0, 1, 0, 16'h0000, 15, 1, 16'h0000, 0, 0, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].c, tbl[i].e, tbl[i].v, tbl[i].dd, tbl[i].s);
      if (tbl[i].chk) check($sformatf("vec%0d", i), tbl[i].eq, tbl[i].ev, tbl[i].eb, tbl[i].eo);
      advance();
    end

    // After the mid-run reset every stage must read back as an empty zero word.
    for (int s = 1; s <= MAXD; s++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b1, 16'(s * 16'h1111), 4'(s));
      check($sformatf("post_rst_stage%0d", s), 16'h0000, 1'b0, 1'b0, 0);
      advance();
    end

    // Randomised traffic against the history model.
    rs = 4'($urandom_range(0, 15));
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 19) == 0) rs = 4'($urandom_range(0, 15));
      drive(($urandom_range(0, 63) != 0),
            ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)),
            16'($urandom),
            rs);
      model_out(eq, ev, eb, eo);
      check($sformatf("rand%0d", n), eq, ev, eb, eo);
      advance();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
